du_word_sender: RTL
===================

# du_word_sender

Buffers 32-bit debug words (PC, register-bank and data-memory values) produced by the debug unit and serializes each into bytes on the debug UART transmitter, using the UART's `tx_start`/`tx_done` handshake. It sits between the debug unit's dump logic and the UART TX path. The debug unit can post words back-to-back without tracking per-byte UART completion.

## Interface
- `BYTE`, 8, UART data width
- `DWORD`, 32, word width; must equal 4*BYTE
- `FIFO_DEPTH`, 4, word buffer depth; power of two, ≥2

Ports:
- `i_clock`  in  1  system clock; single clock domain.
- `i_reset`  in  1  asynchronous, active-low reset.
- `i_word`  in  DWORD  word to transmit.
- `i_word_valid`  in  1  push request; sampled on the rising edge.
- `o_word_ready`  out  1  high when the FIFO is not full.
- `i_tx_done`  in  1  one-cycle pulse from the UART when a byte finishes.
- `o_tx_data`  out  BYTE  byte presented to the UART.
- `o_tx_start`  out  1  one-cycle start pulse to the UART.
- `o_busy`  out  1  high when the FIFO is non-empty or the FSM is not IDLE.
- `o_overflow`  out  1  sticky flag: a push was attempted while full.

## Operation
- Push: `i_word_valid && o_word_ready` writes `i_word` into the FIFO.
- Overflow: `i_word_valid && !o_word_ready` drops the word and sets `o_overflow`. The flag clears only on reset.
- FSM states: IDLE, SEND, WAIT, plus CSUM when the checksum is enabled.
  - IDLE: if the FIFO is non-empty, pop the head into the shift register, set byte index to 0, go to SEND. Otherwise stay.
  - SEND: `o_tx_start`=1 for exactly this cycle. `o_tx_data` = byte[idx]. Go to WAIT.
  - WAIT: hold `o_tx_data`. On `i_tx_done`:
    - if idx<3: idx+1, go to SEND.
    - if idx==3: go to IDLE, or to CSUM if enabled.
- Byte order is LSB first: `[7:0]`, `[15:8]`, `[23:16]`, `[31:24]`.
- `i_tx_done` is ignored outside WAIT.
- Simultaneous push and pop: both occur. Count is unchanged, and `o_word_ready` is computed from the pre-edge count.
- The FIFO uses wrap-around pointers of log2(FIFO_DEPTH) bits plus a separate count register of log2(FIFO_DEPTH)+1 bits.
- Reset mid-word abandons the word. The FIFO is emptied and no further `o_tx_start` is issued.

## Timing
- Reset values:
  - `o_word_ready`=1
  - `o_tx_data`=0
  - `o_tx_start`=0
  - `o_busy`=0
  - `o_overflow`=0
  - FSM=IDLE, count=0, idx=0
- All outputs are registered or decoded from registered state. No input-to-output combinational path exists.
- Empty FIFO, valid in cycle k: the word is written at edge k; IDLE pops at edge k+1; `o_tx_start` is high in cycle k+2.
- From `i_tx_done` in cycle j, the next `o_tx_start` is in cycle j+1.
- Per word, cost is 4×(UART frame time + 1 cycle) + 1 cycle, plus one more frame when the checksum is enabled.
- Back-to-back words: after the final `i_tx_done`, IDLE is entered for one cycle, then SEND.

## Configuration
- `DU_TX_CHECKSUM_EN` defined:
  - After byte 3 completes, the FSM enters CSUM.
  - CSUM sends the XOR of the 4 data bytes with a one-cycle `o_tx_start`, then waits for `i_tx_done` before returning to IDLE.
  - The 5-byte frame is used by the host script for integrity checking.
- `DU_TX_CHECKSUM_EN` undefined:
  - The CSUM state and the XOR register are not compiled.
  - Exactly 4 bytes are sent per word.

## Structure
- Shared package `du_tx_pkg`:
  - FSM state encoding.
  - `BYTES_PER_WORD`=4.
  - Byte-index width constant.
- One sub-module, `du_word_fifo`: synchronous FIFO parameterized by width and depth, with push/pop/full/empty/count.
- The top level holds the FSM, shift register, byte index and overflow flag.

## Test plan
- Reset released, push 0x11223344: `o_tx_start` pulses in cycle k+2 with 0x44. Each `i_tx_done` (model delay 10 cycles) yields 0x33, 0x22, 0x11. Then `o_busy`=0.
- Push 5 words in consecutive cycles with the UART stalled:
  - `o_word_ready` falls after the 4th word is buffered (one is popped to the shift register, so the 5th is accepted).
  - A 6th push sets `o_overflow`; that word is never transmitted.
  - The sent sequence exactly matches the accepted words.
- Pulse `i_tx_done` during SEND and during IDLE: no index advance, no extra `o_tx_start`.
- Assert `i_reset`=0 while in WAIT on byte 2: all outputs go to reset values immediately. After release, no bytes appear until a new push.
- `DU_TX_CHECKSUM_EN` defined, push 0xA5A50F0F: bytes 0x0F, 0x0F, 0xA5, 0xA5, then 0x00. Push 0x01020304: checksum byte is 0x04.
- Simultaneous push and pop with count=2 in IDLE: count stays 2 and the FIFO order is preserved.

Source files
------------

// File: rtl/du_tx_pkg.sv
// Shared definitions for the debug-unit word sender: FSM encoding and byte-lane constants.
// ST_CSUM exists only when DU_TX_CHECKSUM_EN is defined.
package du_tx_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int IDX_W          = $clog2(BYTES_PER_WORD);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
`ifdef DU_TX_CHECKSUM_EN
    ,
    ST_CSUM = 2'd3
`endif
  } tx_state_e;

endpackage

// File: rtl/du_word_fifo.sv
// Synchronous word FIFO with wrap-around pointers and a separate occupancy counter.
// The head word is read combinationally so a pop can load it on the same edge.
module du_word_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count_reg == CNT_W'(DEPTH));
  assign empty    = (count_reg == '0);
  assign count    = count_reg;
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      // Simultaneous push and pop leave the occupancy unchanged.
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/du_word_sender.sv
// Buffers 32-bit debug words and streams them LSB-first to the UART via tx_start/tx_done.
// Define DU_TX_CHECKSUM_EN to append an XOR checksum byte after every word.
module du_word_sender #(
  parameter int BYTE       = 8,
  parameter int DWORD      = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic [DWORD-1:0] i_word,
  input  logic             i_word_valid,
  output logic             o_word_ready,
  input  logic             i_tx_done,
  output logic [BYTE-1:0]  o_tx_data,
  output logic             o_tx_start,
  output logic             o_busy,
  output logic             o_overflow
);

  import du_tx_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  tx_state_e        state_reg;
  tx_state_e        state_next;
  logic [DWORD-1:0] shift_reg;
  logic [IDX_W-1:0] idx_reg;
  logic             overflow_reg;

  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [DWORD-1:0] fifo_head;
  logic             pop;
  logic             last_byte;
  logic             tx_start;
  logic [BYTE-1:0]  tx_data;

  assign pop       = (state_reg == ST_IDLE) && !fifo_empty;
  assign last_byte = (idx_reg == IDX_W'(BYTES_PER_WORD - 1));

  du_word_fifo #(
    .WIDTH (DWORD),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (i_clock),
    .rst_n     (i_reset),
    .push      (i_word_valid),
    .push_data (i_word),
    .pop       (pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

`ifdef DU_TX_CHECKSUM_EN
  logic [BYTE-1:0] head_lane [BYTES_PER_WORD];
  logic [BYTE-1:0] head_xor;
  logic [BYTE-1:0] csum_reg;
  logic            csum_phase_reg;

  for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
    assign head_lane[gi] = fifo_head[gi*BYTE +: BYTE];
  end

  always_comb begin
    head_xor = '0;
    for (int i = 0; i < BYTES_PER_WORD; i++) begin
      head_xor = head_xor ^ head_lane[i];
    end
  end
`endif

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (!fifo_empty) state_next = ST_SEND;
      ST_SEND: state_next = ST_WAIT;
      ST_WAIT: begin
        if (i_tx_done) begin
`ifdef DU_TX_CHECKSUM_EN
          if (csum_phase_reg)  state_next = ST_IDLE;
          else if (last_byte)  state_next = ST_CSUM;
          else                 state_next = ST_SEND;
`else
          state_next = last_byte ? ST_IDLE : ST_SEND;
`endif
        end
      end
`ifdef DU_TX_CHECKSUM_EN
      ST_CSUM: state_next = ST_WAIT;
`endif
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_start = (state_reg == ST_SEND);
    tx_data  = shift_reg[BYTE-1:0];
`ifdef DU_TX_CHECKSUM_EN
    if (state_reg == ST_CSUM) tx_start = 1'b1;
    if (csum_phase_reg)       tx_data  = csum_reg;
`endif
  end

  // Datapath: the shift register drops one byte per completed transfer so byte 0 is always current.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      shift_reg      <= '0;
      idx_reg        <= '0;
      overflow_reg   <= 1'b0;
`ifdef DU_TX_CHECKSUM_EN
      csum_reg       <= '0;
      csum_phase_reg <= 1'b0;
`endif
    end else begin
      if (i_word_valid && fifo_full) begin
        overflow_reg <= 1'b1;
      end
      if (pop) begin
        shift_reg <= fifo_head;
        idx_reg   <= '0;
`ifdef DU_TX_CHECKSUM_EN
        csum_reg  <= head_xor;
`endif
      end else if (state_reg == ST_WAIT && i_tx_done) begin
`ifdef DU_TX_CHECKSUM_EN
        if (csum_phase_reg) begin
          csum_phase_reg <= 1'b0;
        end else if (last_byte) begin
          csum_phase_reg <= 1'b1;
        end else begin
          idx_reg   <= idx_reg + IDX_W'(1);
          shift_reg <= {{BYTE{1'b0}}, shift_reg[DWORD-1:BYTE]};
        end
`else
        if (!last_byte) begin
          idx_reg   <= idx_reg + IDX_W'(1);
          shift_reg <= {{BYTE{1'b0}}, shift_reg[DWORD-1:BYTE]};
        end
`endif
      end
    end
  end

  assign o_word_ready = !fifo_full;
  assign o_tx_start   = tx_start;
  assign o_tx_data    = tx_data;
  assign o_busy       = (fifo_count != '0) || (state_reg != ST_IDLE);
  assign o_overflow   = overflow_reg;

endmodule
